// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset constants,
// fetch FSM state encoding and the {inst, addr, valid} word carried to IF/ID.
package ifu_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        valid;
  } fetch_word_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/ifu_fetch_buf.sv
// One-entry skid buffer that parks a fetched word while IF/ID is stalled.
module ifu_fetch_buf
  import ifu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  fetch_word_t wr_word_i,
  input  logic        rd_en_i,
  input  logic        flush_i,
  output fetch_word_t rd_word_o
);

  fetch_word_t entry_q;

  // Flush beats write beats read; a full entry is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else if (flush_i) begin
      entry_q <= '0;
    end else if (wr_en_i && !entry_q.valid) begin
      entry_q <= wr_word_i;
    end else if (rd_en_i) begin
      entry_q.valid <= 1'b0;
    end
  end

  assign rd_word_o = entry_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch in flight,
// and feeds {inst, addr, valid} into IF/ID with stall and redirect support.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam fetch_word_t BUBBLE = '{inst: NOP_INST, addr: 32'h0, valid: 1'b0};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         kill_q, kill_d;
  fetch_word_t  out_q, out_d;

  logic         reqFire;
  logic         deliver;
  logic         bufWr, bufRd, bufFlush;
  fetch_word_t  newWord;
  fetch_word_t  bufWord;

  // While a killed response is still owed we must not issue another request,
  // otherwise two fetches would be in flight.
  assign imem_req_valid_o = (state_q == REQ) && !kill_q;
  assign imem_req_addr_o  = pc_q;
  assign reqFire          = imem_req_valid_o && imem_req_ready_i;
  assign deliver          = (state_q == WAIT) && imem_rsp_valid_i && !kill_q;
  assign newWord          = '{inst: imem_rsp_data_i, addr: pc_q, valid: 1'b1};

  ifu_fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bufWr),
    .wr_word_i (newWord),
    .rd_en_i   (bufRd),
    .flush_i   (bufFlush),
    .rd_word_o (bufWord)
  );

  // Next-state logic: redirect first, then the normal fetch sequence, then
  // the IF/ID output register (frozen while stalled, bubble when idle).
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    out_d    = out_q;
    bufWr    = 1'b0;
    bufRd    = 1'b0;
    bufFlush = 1'b0;

    // Any response seen while kill is set is the stale one we were waiting to drop.
    if (imem_rsp_valid_i && kill_q) begin
      kill_d = 1'b0;
    end

    if (jump_en_i) begin
      pc_d     = word_align(jump_addr_i);
      out_d    = BUBBLE;
      bufFlush = 1'b1;
      state_d  = REQ;
      // A response landing in this same cycle is simply discarded, so kill is
      // only needed when a fetch is still owed after this edge.
      if ((state_q == WAIT && !imem_rsp_valid_i) || reqFire) begin
        kill_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (reqFire) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            state_d = REQ;
            if (deliver) begin
              pc_d = pc_q + 32'd4;
              if (hold_i) begin
                bufWr   = 1'b1;
                state_d = HOLD;
              end else begin
                out_d = newWord;
              end
            end
          end
        end
        HOLD: begin
          if (!hold_i) begin
            out_d   = bufWord;
            bufRd   = 1'b1;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase

      if (!hold_i && !deliver && state_q != HOLD) begin
        out_d = BUBBLE;
      end
    end
  end

  // State, PC, kill flag and IF/ID output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      out_q   <= BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      out_q   <= out_d;
    end
  end

  assign inst_o       = out_q.inst;
  assign inst_addr_o  = out_q.addr;
  assign inst_valid_o = out_q.valid;

endmodule
